// File: rtl/ldst_sram_slv_if.sv
// Load/store request/response bundle between the core's LSU (master) and a data-memory responder (slave).
// req_pkt = {addr, st, data, strobe}; rsp_pkt = {data, ok}.
interface ldst_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic                     req_vld;
  logic                     req_rdy;
  logic [AW+XLEN+XLEN/8:0]  req_pkt;
  logic                     rsp_vld;
  logic                     rsp_rdy;
  logic [XLEN:0]            rsp_pkt;

  modport master (output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
  modport slave  (input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
endinterface

// File: rtl/ldst_sram_slv.sv
// Data-memory responder: serves ldst_if requests from an internal single-port SRAM, in-order responses via a FIFO.
// Optional macro LDST_SRAM_ALIGN_CHK_EN rejects accesses whose byte-offset bits are non-zero.
module ldst_sram_slv #(
  parameter int                RV_XLEN   = 32,
  parameter int                RV_AW     = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [RV_AW-1:0]  BASE_ADDR = 32'h8000_0000,
  parameter int                RSP_DEPTH = 3
) (
  input  logic  clk,
  input  logic  rst,
  ldst_if.slave ldst
);

  localparam int NB    = RV_XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1) + 1;
  localparam logic [RV_AW:0] MEM_BYTES = (RV_AW + 1)'(DEPTH * NB);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(RSP_DEPTH - 1);

  logic [RV_AW-1:0]   req_addr;
  logic               req_st;
  logic [RV_XLEN-1:0] req_data;
  logic [NB-1:0]      req_strb;
  logic [RV_AW-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic               in_range;
  logic               addr_ok;
  logic               req_rdy;
  logic               accept;
  logic               sram_we;
  logic               sram_re;

  logic [RV_XLEN-1:0] sram_mem [DEPTH];
  logic [RV_XLEN-1:0] sram_rdata;

  logic               s1_vld_q, s1_vld_d;
  logic               s1_ld_q, s1_ld_d;
  logic               s1_ok_q, s1_ok_d;

  logic [RV_XLEN:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      occ;
  logic               push;
  logic               pop;
  logic               rsp_vld;
  logic [RV_XLEN:0]   push_pkt;

  assign {req_addr, req_st, req_data, req_strb} = ldst.req_pkt;

  // Offset subtraction keeps the upper-bound test safe even when BASE_ADDR + size would wrap.
  assign off      = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
  assign idx      = off[OFF_W +: IDX_W];

`ifdef LDST_SRAM_ALIGN_CHK_EN
  assign addr_ok = in_range && (req_addr[OFF_W-1:0] == '0);
`else
  assign addr_ok = in_range;
`endif

  assign occ     = cnt_q + CW'(s1_vld_q);
  assign req_rdy = !rst && (occ < CW'(RSP_DEPTH));
  assign accept  = ldst.req_vld && req_rdy;
  assign sram_we = accept && req_st && addr_ok;
  assign sram_re = accept && !req_st && addr_ok;

  always_ff @(posedge clk) begin
    if (sram_re) sram_rdata <= sram_mem[idx];
    for (int i = 0; i < NB; i++) begin
      if (sram_we && req_strb[i]) sram_mem[idx][i*8 +: 8] <= req_data[i*8 +: 8];
    end
  end

  assign rsp_vld  = (cnt_q != '0);
  assign pop      = rsp_vld && ldst.rsp_rdy;
  assign push     = s1_vld_q;
  assign push_pkt = {(s1_ld_q ? sram_rdata : {RV_XLEN{1'b0}}), s1_ok_q};

  always_comb begin
    s1_vld_d = accept;
    s1_ld_d  = sram_re;
    s1_ok_d  = addr_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_ld_q  <= 1'b0;
      s1_ok_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_ld_q  <= s1_ld_d;
      s1_ok_q  <= s1_ok_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage is data-only; validity lives entirely in cnt_q.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr_q] <= push_pkt;
  end

  assign ldst.req_rdy = req_rdy;
  assign ldst.rsp_vld = rsp_vld;
  assign ldst.rsp_pkt = rsp_vld ? fifo_mem[rd_ptr_q] : '0;

endmodule
